// File: rtl/nn_job_ctrl_if.sv
// nn_job_ctrl_if
//   Bundles every stream and side-band signal of the nn job controller.
//   Handshake rule for both streams (s_* and m_*): a transfer happens on the
//   rising clock edge where valid && ready are both high; the sender keeps
//   valid and data stable until that edge, and ready may depend on state only.
//   Modports:
//     slave  - the job controller (accepts jobs, drives nn and results)
//     master - the environment (job source, nn core, result consumer)
interface nn_job_ctrl_if #(
  parameter int DATAWIDTH = 32
);
  // job input stream
  logic                 s_valid;
  logic                 s_ready;
  logic [DATAWIDTH-1:0] s_in1;
  logic [DATAWIDTH-1:0] s_in2;
  // nn core side
  logic                 nn_enable;
  logic [DATAWIDTH-1:0] nn_input_1;
  logic [DATAWIDTH-1:0] nn_input_2;
  logic [DATAWIDTH-1:0] nn_final_output;
  logic                 nn_total_ovf;
  logic                 nn_total_zero;
  logic [2:0]           nn_ovf_stage;
  logic [2:0]           nn_zero_stage;
  // result stream
  logic                 m_valid;
  logic                 m_ready;
  logic [DATAWIDTH-1:0] m_result;
  logic                 m_ovf;
  logic                 m_zero;
  logic [2:0]           m_ovf_stage;
  logic [2:0]           m_zero_stage;
  // status
  logic                 busy;

  modport slave (
    input  s_valid, s_in1, s_in2,
    input  nn_final_output, nn_total_ovf, nn_total_zero, nn_ovf_stage, nn_zero_stage,
    input  m_ready,
    output s_ready,
    output nn_enable, nn_input_1, nn_input_2,
    output m_valid, m_result, m_ovf, m_zero, m_ovf_stage, m_zero_stage,
    output busy
  );

  modport master (
    output s_valid, s_in1, s_in2,
    output nn_final_output, nn_total_ovf, nn_total_zero, nn_ovf_stage, nn_zero_stage,
    output m_ready,
    input  s_ready,
    input  nn_enable, nn_input_1, nn_input_2,
    input  m_valid, m_result, m_ovf, m_zero, m_ovf_stage, m_zero_stage,
    input  busy
  );
endinterface

// File: rtl/nn_job_ctrl.sv
// nn_job_ctrl
//   Front-end and result collector for the nn forward-pass core. Input pairs
//   are queued in a small FIFO; after the nn weight-load window the FSM issues
//   one job at a time (one-cycle enable with inputs held), waits out the fixed
//   nn latency, captures the nn outputs and offers them on the result stream.
//   Ports:
//     clk         - rising-edge clock shared with nn
//     resetn      - asynchronous active-low reset shared with nn
//     bus         - nn_job_ctrl_if.slave: s_* job stream, nn_* core signals,
//                   m_* result stream, busy
//     o_dbg_state - current FSM state (INIT=0 IDLE=1 ISSUE=2 WAIT=3 CAPTURE=4)
module nn_job_ctrl #(
  parameter int DATAWIDTH   = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int LOAD_CYCLES = 9,
  parameter int NN_LATENCY  = 5
) (
  input  logic         clk,
  input  logic         resetn,
  nn_job_ctrl_if.slave bus,
  output logic [2:0]   o_dbg_state
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int INIT_W = $clog2(LOAD_CYCLES + 2) + 1;
  localparam int WAIT_W = $clog2(NN_LATENCY) + 1;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  state_t                r_state;
  logic [INIT_W-1:0]     r_init_cnt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic                  r_nn_enable;
  logic [DATAWIDTH-1:0]  r_nn_in1;
  logic [DATAWIDTH-1:0]  r_nn_in2;
  logic                  r_m_valid;
  logic [DATAWIDTH-1:0]  r_m_result;
  logic                  r_m_ovf;
  logic                  r_m_zero;
  logic [2:0]            r_m_ovf_stage;
  logic [2:0]            r_m_zero_stage;

  logic [DATAWIDTH-1:0]  r_mem1 [FIFO_DEPTH];
  logic [DATAWIDTH-1:0]  r_mem2 [FIFO_DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_s_ready;
  logic                  w_push;
  logic                  w_issue;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  // No pushes while nn is still loading weights.
  assign w_s_ready = (r_state != S_INIT) && !w_full;
  assign w_push    = bus.s_valid && w_s_ready;
  // A pending result blocks the next job unless it is being accepted on this
  // same edge; that lookahead gives back-to-back jobs every NN_LATENCY+3 cycles.
  assign w_issue   = (r_state == S_IDLE) && !w_empty && (!r_m_valid || bus.m_ready);

  // FIFO storage carries no reset: the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem1[r_wr_ptr[AW-1:0]] <= bus.s_in1;
      r_mem2[r_wr_ptr[AW-1:0]] <= bus.s_in2;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_INIT;
      r_init_cnt     <= '0;
      r_wait_cnt     <= '0;
      r_nn_enable    <= 1'b0;
      r_nn_in1       <= '0;
      r_nn_in2       <= '0;
      r_m_valid      <= 1'b0;
      r_m_result     <= '0;
      r_m_ovf        <= 1'b0;
      r_m_zero       <= 1'b0;
      r_m_ovf_stage  <= '0;
      r_m_zero_stage <= '0;
    end else begin
      if (r_m_valid && bus.m_ready) r_m_valid <= 1'b0;
      case (r_state)
        S_INIT: begin
          // LOAD_CYCLES of weight load, one cycle for nn to reach IDLE, one spare.
          if (r_init_cnt == INIT_W'(LOAD_CYCLES + 1)) r_state <= S_IDLE;
          else r_init_cnt <= r_init_cnt + INIT_W'(1);
        end
        S_IDLE: begin
          if (w_issue) begin
            r_nn_enable <= 1'b1;
            r_nn_in1    <= r_mem1[r_rd_ptr[AW-1:0]];
            r_nn_in2    <= r_mem2[r_rd_ptr[AW-1:0]];
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_nn_enable <= 1'b0;
          r_wait_cnt  <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt == WAIT_W'(NN_LATENCY - 1)) r_state <= S_CAPTURE;
          else r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
        S_CAPTURE: begin
          r_m_result     <= bus.nn_final_output;
          r_m_ovf        <= bus.nn_total_ovf;
          r_m_zero       <= bus.nn_total_zero;
          r_m_ovf_stage  <= bus.nn_ovf_stage;
          r_m_zero_stage <= bus.nn_zero_stage;
          r_m_valid      <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign bus.s_ready      = w_s_ready;
  assign bus.nn_enable    = r_nn_enable;
  assign bus.nn_input_1   = r_nn_in1;
  assign bus.nn_input_2   = r_nn_in2;
  assign bus.m_valid      = r_m_valid;
  assign bus.m_result     = r_m_result;
  assign bus.m_ovf        = r_m_ovf;
  assign bus.m_zero       = r_m_zero;
  assign bus.m_ovf_stage  = r_m_ovf_stage;
  assign bus.m_zero_stage = r_m_zero_stage;
  assign bus.busy         = (r_state != S_IDLE);
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_nn_job_ctrl.sv
// tb_nn_job_ctrl
//   Directed bench for nn_job_ctrl. A small behavioural nn stand-in presents
//   its result only between edges E0+6 and E0+7 (junk otherwise), so the
//   controller must capture on exactly the right edge. Results are compared
//   against hand-computed constants held in an expected queue.
module tb_nn_job_ctrl;
  localparam int DW          = 32;
  localparam int FIFO_DEPTH  = 4;
  localparam int LOAD_CYCLES = 9;
  localparam int NN_LATENCY  = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  logic [2:0] dbg_state;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nn_job_ctrl_if #(.DATAWIDTH(DW)) bus ();

  nn_job_ctrl #(
    .DATAWIDTH(DW), .FIFO_DEPTH(FIFO_DEPTH),
    .LOAD_CYCLES(LOAD_CYCLES), .NN_LATENCY(NN_LATENCY)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .o_dbg_state(dbg_state)
  );

  // ---------------- nn stand-in ----------------
  function automatic logic [39:0] nn_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    logic ovf, zero;
    s    = a + b;
    ovf  = (a[31] == b[31]) && (s[31] != a[31]);
    zero = !ovf && (s == 32'h0);
    return {(zero ? 3'd2 : 3'd0), (ovf ? 3'd5 : 3'd0), zero, ovf, (ovf ? 32'hFFFFFFFF : s)};
  endfunction

  int nn_cnt;
  logic [31:0] nn_a, nn_b;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      nn_cnt <= -1;
      {bus.nn_zero_stage, bus.nn_ovf_stage, bus.nn_total_zero, bus.nn_total_ovf,
       bus.nn_final_output} <= {3'd7, 3'd7, 1'b1, 1'b1, 32'hDEADBEEF};
    end else if (bus.nn_enable === 1'b1) begin
      nn_cnt <= 0;
      nn_a   <= bus.nn_input_1;
      nn_b   <= bus.nn_input_2;
    end else if (nn_cnt == NN_LATENCY - 1) begin
      nn_cnt <= NN_LATENCY;
      {bus.nn_zero_stage, bus.nn_ovf_stage, bus.nn_total_zero, bus.nn_total_ovf,
       bus.nn_final_output} <= nn_model(nn_a, nn_b);
    end else if (nn_cnt == NN_LATENCY) begin
      nn_cnt <= -1;
      {bus.nn_zero_stage, bus.nn_ovf_stage, bus.nn_total_zero, bus.nn_total_ovf,
       bus.nn_final_output} <= {3'd7, 3'd7, 1'b1, 1'b1, 32'hDEADBEEF};
    end else if (nn_cnt >= 0) begin
      nn_cnt <= nn_cnt + 1;
    end
  end

  // enable monitor: records the cycle number of the edge that raised nn_enable
  int en_q[$];
  int last_en = 0;
  always @(posedge clk) begin
    if (bus.nn_enable === 1'b1) begin
      en_q.push_back(cyc);
      last_en = cyc;
    end
  end

  // ---------------- scoreboard ----------------
  logic [39:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [39:0] exp_pack(input logic [31:0] r, input logic ovf,
                                           input logic zero, input logic [2:0] os,
                                           input logic [2:0] zs);
    return {zs, os, zero, ovf, r};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"},   bus.s_ready, 0);
    check({tag, "_nn_enable"}, bus.nn_enable, 0);
    check({tag, "_nn_inputs"}, {bus.nn_input_1, bus.nn_input_2}, 0);
    check({tag, "_m_valid"},   bus.m_valid, 0);
    check({tag, "_m_fields"},  {bus.m_zero_stage, bus.m_ovf_stage, bus.m_zero, bus.m_ovf,
                                bus.m_result}, 0);
    check({tag, "_busy"},      bus.busy, 1);
    check({tag, "_state"},     dbg_state, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [39:0] exp);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_in1   = a;
    bus.s_in2   = b;
    while (bus.s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("push_timeout_s_ready", bus.s_ready, 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    exp_q.push_back(exp);
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    logic [39:0] exp, got;
    while (bus.m_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_m_valid"}, bus.m_valid, 1);
    if (bus.m_valid === 1'b1) begin
      check({tag, "_latency"}, cyc - last_en, 7);
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected"}, exp_q.size(), 1);
      end else begin
        exp = exp_q.pop_front();
        got = {bus.m_zero_stage, bus.m_ovf_stage, bus.m_zero, bus.m_ovf, bus.m_result};
        check({tag, "_data"}, got, exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.m_valid !== 1'b0) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int bad;
    int n_en;
    logic [31:0] held;

    resetn      = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_in1   = '0;
    bus.s_in2   = '0;
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    // A: push held off through INIT, then one job (overflowing pair)
    bus.s_valid = 1'b1;
    bus.s_in1   = 32'h690c5b55;
    bus.s_in2   = 32'h6a325e4a;
    resetn      = 1'b1;
    bad = 0;
    for (int i = 0; i < LOAD_CYCLES + 2; i++) begin
      if (bus.s_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
      @(negedge clk);
    end
    check("init_s_ready_low", bad, 0);
    check("init_done_s_ready", bus.s_ready, 1);
    check("init_done_busy", bus.busy, 0);
    check("init_done_state", dbg_state, 1);
    check("init_no_issue", en_q.size(), 0);
    push(32'h690c5b55, 32'h6a325e4a, exp_pack(32'hFFFFFFFF, 1, 0, 3'd5, 3'd0));
    wait_result("a_first");
    expect_quiet("a_no_extra_result", 15);
    check("a_single_issue", en_q.size(), 1);

    // B: five back-to-back pushes fill the FIFO; rejected push while full
    en_q.delete();
    push(32'd1, 32'd2, exp_pack(32'd3, 0, 0, 3'd0, 3'd0));
    push(32'd10, 32'd20, exp_pack(32'h1E, 0, 0, 3'd0, 3'd0));
    push(32'hFFFFFFFB, 32'd3, exp_pack(32'hFFFFFFFE, 0, 0, 3'd0, 3'd0));
    push(32'h1000, 32'h0234, exp_pack(32'h1234, 0, 0, 3'd0, 3'd0));
    push(32'h12345678, 32'h11111111, exp_pack(32'h23456789, 0, 0, 3'd0, 3'd0));
    check("b_full_s_ready", bus.s_ready, 0);
    bus.s_valid = 1'b1;
    bus.s_in1   = 32'h55;
    bus.s_in2   = 32'h55;
    @(negedge clk);
    check("b_full_hold1", bus.s_ready, 0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    for (int k = 0; k < 5; k++) wait_result($sformatf("b_res%0d", k));
    check("b_issue_count", en_q.size(), 5);
    for (int k = 1; k < en_q.size(); k++)
      check($sformatf("b_period%0d", k), en_q[k] - en_q[k-1], 8);
    expect_quiet("b_rejected_push_dropped", 20);

    // C: consumer stalls with two jobs queued
    bus.m_ready = 1'b0;
    push(32'd7, 32'd8, exp_pack(32'hF, 0, 0, 3'd0, 3'd0));
    push(32'h100, 32'h200, exp_pack(32'h300, 0, 0, 3'd0, 3'd0));
    push(32'h40000000, 32'h3FFFFFFF, exp_pack(32'h7FFFFFFF, 0, 0, 3'd0, 3'd0));
    wait_result("c_res0");
    held = bus.m_result;
    n_en = en_q.size();
    bad  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.m_valid !== 1'b1 || bus.m_result !== held || bus.nn_enable !== 1'b0) bad++;
    end
    check("c_stall_stable", bad, 0);
    check("c_stall_no_issue", en_q.size(), n_en);
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("c_release_issue", bus.nn_enable, 1);
    check("c_release_m_valid", bus.m_valid, 0);
    wait_result("c_res1");
    wait_result("c_res2");

    // D: overflow pass-through
    push(32'h7FFFFFFF, 32'h7FFFFFFF, exp_pack(32'hFFFFFFFF, 1, 0, 3'd5, 3'd0));
    push(32'h80000000, 32'hFFFFFFFF, exp_pack(32'hFFFFFFFF, 1, 0, 3'd5, 3'd0));
    wait_result("d_ovf0");
    wait_result("d_ovf1");

    // E: reset in the middle of WAIT with two jobs queued
    push(32'd1, 32'd1, 40'h0);
    push(32'd2, 32'd2, 40'h0);
    push(32'd3, 32'd3, 40'h0);
    @(negedge clk);
    @(negedge clk);
    check("e_in_wait", dbg_state, 3);
    resetn = 1'b0;
    #1;
    check_reset_vals("e_reset");
    exp_q.delete();
    n_en = en_q.size();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < LOAD_CYCLES + 2; i++) begin
      if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.nn_enable !== 1'b0) bad++;
      @(negedge clk);
    end
    check("e_reinit", bad, 0);
    check("e_reinit_state", dbg_state, 1);
    expect_quiet("e_no_stale_result", 25);
    check("e_no_stale_issue", en_q.size(), n_en);

    // F: zero results
    push(32'd0, 32'd0, exp_pack(32'd0, 0, 1, 3'd0, 3'd2));
    push(32'd100, 32'hFFFFFF9C, exp_pack(32'd0, 0, 1, 3'd0, 3'd2));
    wait_result("f_zero0");
    wait_result("f_zero1");
    check("f_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
